// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial adder: datapath byte width and FSM state encoding.
package add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_e;

endpackage

// File: rtl/adder_8bit.sv
// Combinational 8-bit ripple adder slice reused every cycle by the byte-serial adder.
module adder_8bit
    import add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_nbyte.sv
// Byte-serial add/subtract: one byte of the operands per cycle through a single 8-bit adder.
// Handshake: a transfer happens on a rising clk where valid and ready are both 1 (in_* side and out_* side).
module add_seq_nbyte
    import add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [1:0]               dbg_state
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    add_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BYTE_W-1:0] add_a, add_b, add_s;
    logic              add_co;

    assign add_a = a_q[idx_q*BYTE_W +: BYTE_W];
    assign add_b = b_q[idx_q*BYTE_W +: BYTE_W];

    adder_8bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so B is inverted here and the carry seeded with 1.
                    a_d     = in_a;
                    b_d     = in_b ^ {W{in_sub}};
                    carry_d = in_sub ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Carry into the MSB is recovered from the MSB's own sum bit.
                    cout_d  = add_co;
                    ovf_d   = add_a[BYTE_W-1] ^ add_b[BYTE_W-1] ^ add_s[BYTE_W-1] ^ add_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_add_seq_nbyte.sv
// Bench for add_seq_nbyte (NBYTES=4): directed vectors, expected results queued at accept time
// and compared by an independent monitor whenever a result is handed over.
module tb_add_seq_nbyte;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, out_cout, out_ovf;
    logic [W-1:0] out_sum;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -1;
    int acc_e;
    logic         prev_valid = 1'b0;
    logic [W+1:0] exp_q[$];
    int           acc_q[$];

    add_seq_nbyte #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset-independent cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            total++;
            if (acc_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: out_valid rose with no pending request (cycle %0d)", cyc);
            end else begin
                total--;
                acc_e = acc_q.pop_front();
                check("latency", 64'(cyc - acc_e), 64'(NB));
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0h with empty queue", {out_cout, out_ovf, out_sum});
            end else begin
                check("result{cout,ovf,sum}", {out_cout, out_ovf, out_sum}, exp_q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    // driver
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W+1:0] exp, input bit keep, input bit track);
        int budget;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        budget = 20;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (track) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc + 1);
        end
        if (keep && last_acc >= 0) check("b2b_spacing", 64'(cyc + 1 - last_acc), 64'd6);
        last_acc = cyc + 1;
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_state", dbg_state, 0);

        out_ready = 1'b1;
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h00000000}, 0, 1);
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE}, 0, 1);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h80000000}, 0, 1);
        drain();

        // consumer stalls for 5 cycles
        out_ready = 1'b0;
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h23456789}, 0, 1);
        budget = 20;
        while (!out_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("hold_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_sum", out_sum, 32'h23456789);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_ack_in_ready", in_ready, 1);
        check("post_ack_out_valid", out_valid, 0);

        // reset during the second RUN cycle aborts the operation
        send(32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, '0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready_async", in_ready, 1);
        check("abort_out_sum_async", out_sum, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_sum", out_sum, 0);
        check("abort_out_cout", out_cout, 0);
        check("abort_out_ovf", out_ovf, 0);
        repeat (8) @(negedge clk);
        check("abort_no_valid", out_valid, 0);

        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000100}, 0, 1);
        send(32'h80000000, 32'h00000001, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF}, 0, 1);
        send(32'h00010000, 32'h00010000, 1'b0, 1'b1, {1'b1, 1'b0, 32'h00000000}, 0, 1);
        drain();

        // back-to-back with in_valid held high
        last_acc = -1;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00010000}, 1, 1);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h00000000}, 1, 1);
        send(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, {1'b1, 1'b0, 32'h00000000}, 1, 1);
        in_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 0);
        check("final_acc_queue_empty", 64'(acc_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
